// File: rtl/core_mon_pkg.sv
// Shared types and helpers for the core run monitor: FSM states, halt-cause bit positions
// and register-mask walking.
package core_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StDump,
    StDone
  } mon_state_e;

  localparam int unsigned HC_BP    = 1;
  localparam int unsigned HC_LIMIT = 0;

  localparam int unsigned MaxMaskW = 64;

  typedef struct packed {
    logic       last;
    logic [5:0] idx;
  } mask_step_t;

  // Next set bit strictly above cur (cur = -1 gives the lowest), plus whether it is the final one.
  function automatic mask_step_t next_mask_idx(input logic [MaxMaskW-1:0] mask, input int cur,
                                               input int nregs);
    mask_step_t r;
    logic       found;
    r     = '0;
    r.last = 1'b1;
    found = 1'b0;
    for (int i = 0; i < MaxMaskW; i++) begin
      if (i < nregs && i > cur && mask[i]) begin
        if (found) begin
          r.last = 1'b0;
        end else begin
          found = 1'b1;
          r.idx = 6'(i);
        end
      end
    end
    return r;
  endfunction

  function automatic logic mask_nonempty(input logic [MaxMaskW-1:0] mask, input int nregs);
    logic any;
    any = 1'b0;
    for (int i = 0; i < MaxMaskW; i++) begin
      if (i < nregs && mask[i]) any = 1'b1;
    end
    return any;
  endfunction

endpackage

// File: rtl/core_bp_match.sv
// Parallel PC breakpoint comparators with per-entry enable, OR-reduced to one hit.
module core_bp_match #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
  input  logic [XLEN-1:0]        pc_i,
  output logic                   hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      if (bp_en_i[i] && (bp_addr_i[i*XLEN +: XLEN] == pc_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/core_run_monitor.sv
// Run control for the pipelined core: run until a cycle limit or breakpoint, drain the
// pipeline, then stream the selected register-file entries over ready/valid.
module core_run_monitor import core_mon_pkg::*; #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned NUM_BP       = 2,
  parameter int unsigned CYCLE_W      = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] DUMP_MASK    = 32'h0000_07F8,
  localparam int unsigned AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [CYCLE_W-1:0]     cycle_limit_i,
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
  input  logic [XLEN-1:0]        pc_i,
  output logic                   fetch_stall_o,
  output logic [AW-1:0]          rf_raddr_o,
  input  logic [XLEN-1:0]        rf_rdata_i,
  output logic                   dump_valid_o,
  input  logic                   dump_ready_i,
  output logic [AW-1:0]          dump_idx_o,
  output logic [XLEN-1:0]        dump_data_o,
  output logic                   dump_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             halt_cause_o,
  output logic [CYCLE_W-1:0]     cycle_count_o
);

  localparam logic [MaxMaskW-1:0] MaskEff   = MaxMaskW'(DUMP_MASK);
  localparam mask_step_t          FirstStep = next_mask_idx(MaskEff, -1, int'(NUM_REGS));
  localparam logic                MaskAny   = mask_nonempty(MaskEff, int'(NUM_REGS));
  localparam int unsigned         DrainN    = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
  localparam int unsigned         DW        = $clog2(DrainN + 1);
  localparam logic [DW-1:0]       DrainLast = DW'(DrainN - 1);

  mon_state_e         state_q, state_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  logic [1:0]         hc_q, hc_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               last_q, last_d;

  logic       bp_hit, limit_hit, stop, start_ok;
  mask_step_t step;

  core_bp_match #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_i      (pc_i),
    .hit_o     (bp_hit)
  );

  assign limit_hit = (cycle_limit_i != '0) && (cnt_q == cycle_limit_i - CYCLE_W'(1));
  assign stop      = (state_q == StRun) && (limit_hit || bp_hit);
  assign start_ok  = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign step      = next_mask_idx(MaskEff, int'(idx_q), int'(NUM_REGS));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start_i) state_d = StRun;
      StRun:          if (limit_hit || bp_hit) state_d = StDrain;
      StDrain:        if (drain_q == DrainLast) state_d = MaskAny ? StDump : StDone;
      StDump:         if (dump_ready_i && last_q) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    hc_d    = hc_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (start_ok) begin
      cnt_d = '0;
      hc_d  = '0;
    end
    if (state_q == StRun) begin
      if (cnt_q != '1) cnt_d = cnt_q + CYCLE_W'(1);
      if (stop) begin
        hc_d[HC_BP]    = bp_hit;
        hc_d[HC_LIMIT] = limit_hit;
        drain_d        = '0;
      end
    end
    if (state_q == StDrain) begin
      drain_d = drain_q + DW'(1);
      idx_d   = AW'(FirstStep.idx);
      last_d  = FirstStep.last;
    end
    // Beat advances only on a handshake so idx/data/last hold under backpressure.
    if (state_q == StDump && dump_ready_i && !last_q) begin
      idx_d  = AW'(step.idx);
      last_d = step.last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      hc_q    <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    fetch_stall_o = (state_q != StRun);
    rf_raddr_o    = idx_q;
    dump_idx_o    = idx_q;
    dump_data_o   = rf_rdata_i;
    dump_valid_o  = (state_q == StDump);
    dump_last_o   = (state_q == StDump) && last_q;
    busy_o        = (state_q == StRun) || (state_q == StDrain) || (state_q == StDump);
    done_o        = (state_q == StDone);
    halt_cause_o  = hc_q;
    cycle_count_o = cnt_q;
  end

endmodule

// File: tb/tb_core_run_monitor.sv
// Scenario bench for core_run_monitor: run/stop causes, drain timing, scoreboarded dump,
// async reset mid-dump and start filtering.
module tb_core_run_monitor;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  logic            clk = 1'b0;
  logic            rst_n, start, fetch_stall, dump_valid, dump_ready, dump_last, busy, done;
  logic [15:0]     cycle_limit, cycle_count;
  logic [1:0]      bp_en, halt_cause;
  logic [63:0]     bp_addr;
  logic [XLEN-1:0] pc_q, rf_rdata, dump_data;
  logic [AW-1:0]   rf_raddr, dump_idx;
  logic            pc_clr;

  always #5 clk = ~clk;

  // Core model: PC advances by 4 whenever fetch is not stalled; regfile holds x[i] = 100 + i.
  always @(posedge clk) begin
    if (pc_clr)            pc_q <= '0;
    else if (!fetch_stall) pc_q <= pc_q + 32'd4;
  end
  assign rf_rdata = 32'd100 + 32'(rf_raddr);

  core_run_monitor dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .cycle_limit_i (cycle_limit),
    .bp_en_i       (bp_en),
    .bp_addr_i     (bp_addr),
    .pc_i          (pc_q),
    .fetch_stall_o (fetch_stall),
    .rf_raddr_o    (rf_raddr),
    .rf_rdata_i    (rf_rdata),
    .dump_valid_o  (dump_valid),
    .dump_ready_i  (dump_ready),
    .dump_idx_o    (dump_idx),
    .dump_data_o   (dump_data),
    .dump_last_o   (dump_last),
    .busy_o        (busy),
    .done_o        (done),
    .halt_cause_o  (halt_cause),
    .cycle_count_o (cycle_count)
  );

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic pulse_start();
    start  = 1'b1;
    pc_clr = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pc_clr = 1'b0;
  endtask

  // Counts unstalled cycles; optionally pokes start on RUN cycle number 'poke'.
  task automatic count_run(input int poke, output int low);
    low = 0;
    while (!fetch_stall && low < 1000) begin
      low++;
      start = (low == poke);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_run(input string name, input logic [15:0] lim, input logic [1:0] en,
                        input logic [63:0] addr, input int poke, input int exp_low,
                        input logic [15:0] exp_cnt, input logic [1:0] exp_hc);
    int low, d;
    cycle_limit = lim;
    bp_en       = en;
    bp_addr     = addr;
    pulse_start();
    count_run(poke, low);
    checks++;
    if (low !== exp_low) begin
      errors++;
      $display("FAIL %s run_cycles: got %0d expected %0d", name, low, exp_low);
    end
    checks++;
    if (cycle_count !== exp_cnt || halt_cause !== exp_hc || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s stop_state: count=%0d hc=%b busy=%b expected count=%0d hc=%b busy=1",
               name, cycle_count, halt_cause, busy, exp_cnt, exp_hc);
    end
    d = 0;
    while (fetch_stall && !dump_valid && d < 100) begin
      d++;
      @(negedge clk);
    end
    checks++;
    if (d !== 4 || dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: got %0d stall cycles valid=%b expected 4 valid=1",
               name, d, dump_valid);
    end
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0,1 repeating.
  task automatic run_dump(input string name, input int mode, input int poke,
                          input int rst_beat);
    int k, beats;
    beat_t b;
    for (int i = 3; i <= 10; i++) begin
      b.idx  = AW'(i);
      b.data = 32'(100 + i);
      b.last = (i == 10);
      sb.push_back(b);
    end
    k     = 0;
    beats = 0;
    while (sb.size() > 0 && k < 200) begin
      dump_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      start      = (poke != 0) && (k == poke);
      if (rst_beat != 0 && beats == rst_beat - 1) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || fetch_stall !== 1'b1 || busy !== 1'b0 ||
            cycle_count !== 16'd0 || done !== 1'b0 || halt_cause !== 2'b00) begin
          errors++;
          $display("FAIL %s async_reset: valid=%b stall=%b busy=%b count=%0d done=%b hc=%b",
                   name, dump_valid, fetch_stall, busy, cycle_count, done, halt_cause);
        end
        sb.delete();
        start      = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      #1;
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== sb[0].idx || dump_data !== sb[0].data ||
          dump_last !== sb[0].last) begin
        errors++;
        $display("FAIL %s beat%0d: valid=%b idx=%0d data=%0d last=%b expected 1 %0d %0d %b",
                 name, beats, dump_valid, dump_idx, dump_data, dump_last,
                 sb[0].idx, sb[0].data, sb[0].last);
      end
      if (dump_ready) begin
        void'(sb.pop_front());
        beats++;
      end
      k++;
      @(negedge clk);
    end
    start      = 1'b0;
    dump_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s dump_timeout: %0d beats outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL %s after_dump: done=%b busy=%b valid=%b stall=%b expected 1 0 0 1",
               name, done, busy, dump_valid, fetch_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (fetch_stall !== 1'b1 || dump_valid !== 1'b0 || dump_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || halt_cause !== 2'b00 || cycle_count !== 16'd0 || rf_raddr !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: stall=%b valid=%b last=%b busy=%b done=%b hc=%b cnt=%0d ra=%0d",
               fetch_stall, dump_valid, dump_last, busy, done, halt_cause, cycle_count,
               rf_raddr);
    end
    rst_n  = 1'b1;
    @(negedge clk);
    pc_clr = 1'b0;
    checks++;
    if (fetch_stall !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: stall=%b busy=%b expected 1 0", fetch_stall, busy);
    end
  endtask

  task automatic test_cycle_limit();
    do_run("limit", 16'd10, 2'b00, 64'd0, 0, 10, 16'd10, 2'b01);
    run_dump("limit", 0, 0, 0);
  endtask

  task automatic test_breakpoint();
    do_run("bp", 16'd0, 2'b10, {32'h0000_0020, 32'hDEAD_0000}, 0, 9, 16'd9, 2'b10);
    run_dump("bp", 0, 0, 0);
  endtask

  task automatic test_both_hit_backpressure();
    do_run("both", 16'd5, 2'b01, {32'hDEAD_0000, 32'h0000_0010}, 0, 5, 16'd5, 2'b11);
    run_dump("both", 1, 0, 0);
  endtask

  task automatic test_reset_mid_dump();
    do_run("rst", 16'd3, 2'b00, 64'd0, 0, 3, 16'd3, 2'b01);
    run_dump("rst", 0, 0, 4);
    do_run("rst_again", 16'd3, 2'b00, 64'd0, 0, 3, 16'd3, 2'b01);
    run_dump("rst_again", 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    int low;
    do_run("poke", 16'd20, 2'b00, 64'd0, 5, 20, 16'd20, 2'b01);
    run_dump("poke", 1, 2, 0);
    pulse_start();
    checks++;
    if (cycle_count !== 16'd0 || halt_cause !== 2'b00 || busy !== 1'b1 || done !== 1'b0 ||
        fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL restart: count=%0d hc=%b busy=%b done=%b stall=%b expected 0 00 1 0 0",
               cycle_count, halt_cause, busy, done, fetch_stall);
    end
    count_run(0, low);
    checks++;
    if (low !== 20 || cycle_count !== 16'd20) begin
      errors++;
      $display("FAIL restart_run: cycles=%0d count=%0d expected 20 20", low, cycle_count);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    cycle_limit = '0;
    bp_en       = '0;
    bp_addr     = '0;
    dump_ready  = 1'b0;
    pc_clr      = 1'b1;
    @(negedge clk);
    test_reset();
    test_cycle_limit();
    test_breakpoint();
    test_both_hit_backpressure();
    test_reset_mid_dump();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_monitor.md
Name: core_run_monitor

Overview:
- Synthesizable run-control and register-dump unit for the five-stage pipelined core.
- Starts the core on command and stops fetch on a cycle limit or on a PC breakpoint.
- After a stop, waits for in-flight instructions to retire, then streams the selected register-file entries out over a ready/valid interface.
- Generalises the fixed-cycle run and register print into hardware with configurable width, register mask, breakpoint count and drain depth.

Parameters:
- XLEN, 32, data and PC width.
- NUM_REGS, 32, number of register-file entries; AW = clog2(NUM_REGS).
- NUM_BP, 2, number of PC breakpoint comparators.
- CYCLE_W, 16, cycle counter and limit width.
- DRAIN_CYCLES, 4, cycles fetch is held before dumping, covering the ID, EX, MEM and WB stages.
- DUMP_MASK, 32'h0000_07F8, bit i set means register x[i] is dumped; default dumps x3..x10.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; accepted only in IDLE or DONE.
- cycle_limit  in  CYCLE_W  number of RUN cycles before stopping; 0 means no limit.
- bp_en  in  NUM_BP  per-breakpoint enable.
- bp_addr  in  NUM_BP*XLEN  breakpoint PCs, packed with breakpoint 0 in the LSBs.
- pc_in  in  XLEN  current fetch PC from the core.
- fetch_stall  out  1  freezes PC and fetch, inserts bubbles, lets later stages drain.
- rf_raddr  out  AW  register-file debug read address.
- rf_rdata  in  XLEN  combinational read data for rf_raddr.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts the beat.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- dump_last  out  1  final beat of the dump.
- busy  out  1  state is RUN, DRAIN or DUMP.
- done  out  1  state is DONE.
- halt_cause  out  2  bit1 = breakpoint hit, bit0 = cycle limit reached.
- cycle_count  out  CYCLE_W  RUN cycles executed, saturating.

Behaviour:
- States: IDLE, RUN, DRAIN, DUMP, DONE.
- Reset (asynchronous, reset=0) forces IDLE, including mid-operation. Reset values: fetch_stall=1, dump_valid=0, dump_last=0, busy=0, done=0, halt_cause=0, cycle_count=0, rf_raddr=0.
- IDLE: fetch_stall=1.
  - start → RUN; in the same edge clear cycle_count and halt_cause.
- RUN: fetch_stall=0; cycle_count increments every cycle and saturates at all-ones.
  - Limit hit: cycle_limit≠0 and cycle_count == cycle_limit-1. Fetch therefore runs exactly cycle_limit cycles.
  - BP hit: any i with bp_en[i] and pc_in == bp_addr[i]. The instruction at the matching PC is fetched and retires (inclusive breakpoint).
  - On either hit → DRAIN; latch halt_cause with both bits set if both hit in the same cycle. cycle_count includes the final cycle.
  - With no limit and no breakpoint, RUN continues indefinitely.
- DRAIN: fetch_stall=1; an internal counter runs DRAIN_CYCLES cycles.
  - Then → DUMP if DUMP_MASK≠0, else → DONE.
- DUMP: fetch_stall=1; iterates idx upward over indices whose DUMP_MASK bit is set, starting at the lowest set bit.
  - rf_raddr = idx, dump_idx = idx, dump_data = rf_rdata. Data is stable because the core is drained and stalled.
  - dump_valid=1 throughout DUMP. idx advances only on dump_valid && dump_ready, so idx, data and last hold while ready is low.
  - dump_last=1 when idx is the highest set mask bit; a handshake with last asserted → DONE.
- DONE: done=1, fetch_stall=1, halt_cause and cycle_count held.
  - start → RUN, as from IDLE.
- start arriving in RUN, DRAIN or DUMP is ignored.
- Mask indices ≥ NUM_REGS are ignored.

Decomposition:
- Package core_mon_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DUMP, DONE);
  - halt-cause bit constants HC_BP=1 and HC_LIMIT=0;
  - a function next_mask_idx(mask, idx) returning the next set bit above idx plus an is-last flag.
- One sub-module, core_bp_match: NUM_BP-wide parallel comparator with per-entry enable, reducing to a single hit bit.

Test Plan:
1. cycle_limit=10, bp_en=0, start → fetch_stall low exactly 10 cycles; cycle_count=10; halt_cause=2'b01; fetch_stall high 4 DRAIN cycles before the first dump_valid.
2. bp_en=2'b10, bp_addr[1]=0x20, cycle_limit=0, pc_in steps 0,4,8… → stall asserts the cycle after pc_in=0x20; cycle_count=9; halt_cause=2'b10.
3. cycle_limit=5 with bp_addr[0]=0x10 hit on cycle 5 → halt_cause=2'b11; cycle_count=5.
4. Default mask, regfile model x[i]=100+i, dump_ready toggling 1,0,0,1… → 8 beats, idx 3..10, data 103..110. Outputs hold while ready is low; dump_last only on idx 10; then done=1.
5. reset driven low during the 4th dump beat → asynchronous return to IDLE: dump_valid=0, fetch_stall=1, busy=0, cycle_count=0. A following start runs cleanly.
6. start pulsed during RUN and DUMP → ignored, cycle_count uninterrupted. start in DONE → restart with cycle_count=0, halt_cause=0.
